// File: rtl/dmem_mmio_responder_pkg.sv
// Shared MMIO address map and status-word layout for the data-memory responder.
package dmem_mmio_responder_pkg;

    localparam logic [31:0] A_TX_DATA = 32'h0000_1000;
    localparam logic [31:0] A_TX_STAT = 32'h0000_1001;
    localparam logic [31:0] A_RX_DATA = 32'h0000_1002;
    localparam logic [31:0] A_RX_POP  = 32'h0000_1003;
    localparam logic [31:0] A_RX_STAT = 32'h0000_1004;
    localparam logic [31:0] A_CYCLES  = 32'h0000_1005;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_FLAG  = 2;
    localparam int ST_CNT   = 16;

    function automatic logic [31:0] stat_word(
        input logic [15:0] cnt,
        input logic        flag,
        input logic        full,
        input logic        empty
    );
        logic [31:0] w;
        w = '0;
        w[ST_CNT +: 16] = cnt;
        w[ST_FLAG]      = flag;
        w[ST_FULL]      = full;
        w[ST_EMPTY]     = empty;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_fifo_sync.sv
// Synchronous FIFO with wrap-bit pointers; push into a full FIFO succeeds only
// when a pop frees a slot in the same cycle.
module fifo_sync
    import dmem_mmio_responder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: backing RAM plus an MMIO page with TX/RX byte
// FIFOs and a free-running cycle counter. Loads return one edge later.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int RAM_BITS = 12,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int RAM_DEPTH = 2 ** RAM_BITS;
    localparam int TXW       = $clog2(TX_DEPTH);
    localparam int RXW       = $clog2(RX_DEPTH);

    logic [31:0] ram [RAM_DEPTH];
    logic [31:0] ram_q;
    logic [31:0] mmio_q;
    logic [31:0] mmio_rd;
    logic        ram_sel_q;
    logic        is_ram;

    logic        wr_tx;
    logic        wr_tx_stat;
    logic        wr_rx_pop;
    logic        wr_rx_stat;
    logic        wr_cycles;

    logic        tx_pop;
    logic        tx_empty;
    logic        tx_full;
    logic [TXW:0] tx_count;
    logic        tx_ovf;

    logic        rx_push;
    logic [7:0]  rx_head;
    logic        rx_empty;
    logic        rx_full;
    logic [RXW:0] rx_count;
    logic        rx_udf;

    logic [31:0] cycles;

    assign is_ram     = (address_dmem[31:RAM_BITS] == '0);
    assign wr_tx      = wren & (address_dmem == A_TX_DATA);
    assign wr_tx_stat = wren & (address_dmem == A_TX_STAT);
    assign wr_rx_pop  = wren & (address_dmem == A_RX_POP);
    assign wr_rx_stat = wren & (address_dmem == A_RX_STAT);
    assign wr_cycles  = wren & (address_dmem == A_CYCLES);

    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    // Gate with reset so the source sees back-pressure for the whole reset window.
    assign rx_ready = reset & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;

    fifo_sync #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_tx),
        .pop   (tx_pop),
        .din   (data[7:0]),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    fifo_sync #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (wr_rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    always_ff @(posedge clock) begin
        if (wren && is_ram) ram[address_dmem[RAM_BITS-1:0]] <= data;
        ram_q <= ram[address_dmem[RAM_BITS-1:0]];
    end

    always_comb begin
        mmio_rd = '0;
        case (address_dmem)
            A_TX_STAT: mmio_rd = stat_word(16'(tx_count), tx_ovf, tx_full, tx_empty);
            A_RX_DATA: mmio_rd = rx_empty ? 32'h0 : {24'h0, rx_head};
            A_RX_STAT: mmio_rd = stat_word(16'(rx_count), rx_udf, rx_full, rx_empty);
            A_CYCLES:  mmio_rd = cycles;
            default:   mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram_sel_q <= 1'b0;
            mmio_q    <= '0;
            tx_ovf    <= 1'b0;
            rx_udf    <= 1'b0;
            cycles    <= '0;
        end else begin
            ram_sel_q <= is_ram;
            mmio_q    <= mmio_rd;
            if (wr_tx && tx_full && !tx_pop) tx_ovf <= 1'b1;
            else if (wr_tx_stat)             tx_ovf <= 1'b0;
            if (wr_rx_pop && rx_empty) rx_udf <= 1'b1;
            else if (wr_rx_stat)       rx_udf <= 1'b0;
            cycles <= wr_cycles ? 32'h0 : cycles + 32'h1;
        end
    end

    assign q_dmem = ram_sel_q ? ram_q : mmio_q;

endmodule
